// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide engine for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with flush/hold handling.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            hold,
    output logic            exe_wait,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] ra, rb, rc, res_q;
    logic [CW-1:0]   cnt;
    logic            mul_q, w_q, rem_q, qneg_q, rneg_q;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

    function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] x, input logic w);
        return w ? sext32(x[31:0]) : x;
    endfunction

    // Operation decode and operand preparation for the acceptance cycle
    logic            is_w, is_mul, is_rsv, is_div, is_sgn, is_rem;
    logic [XLEN-1:0] opa, opb, mag_a, mag_b, spec_res;
    logic            sa, sb, div_zero, ovf, special, accept;

    always_comb begin
        is_w   = op inside {4'd1, 4'd6, 4'd7, 4'd8, 4'd9};
        is_mul = op inside {4'd0, 4'd1};
        is_rsv = op > 4'd9;
        is_div = ~is_mul & ~is_rsv;
        is_sgn = op inside {4'd2, 4'd4, 4'd6, 4'd8};
        is_rem = op inside {4'd4, 4'd5, 4'd8, 4'd9};

        if (is_w) begin
            opa = is_sgn ? sext32(a[31:0]) : {{(XLEN-32){1'b0}}, a[31:0]};
            opb = is_sgn ? sext32(b[31:0]) : {{(XLEN-32){1'b0}}, b[31:0]};
        end else begin
            opa = a;
            opb = b;
        end

        sa    = is_sgn & opa[XLEN-1];
        sb    = is_sgn & opb[XLEN-1];
        mag_a = sa ? -opa : opa;
        mag_b = sb ? -opb : opb;

        div_zero = is_div & (opb == '0);
        ovf      = is_div & is_sgn & (opa == (is_w ? MIN_W : MIN_D)) & (opb == '1);
        special  = is_rsv | div_zero | ovf;

        if (is_rsv)
            spec_res = '0;
        else if (div_zero)
            spec_res = is_rem ? fin(opa, is_w) : '1;
        else
            spec_res = is_rem ? '0 : fin(opa, is_w);

        accept = (state == IDLE) & valid & ~flush;
    end

    // One iteration of the datapath plus the final sign fix-up
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] sum, nra, nrb, nrc, quo, rmd, fres;

    always_comb begin
        sum     = ra + rb;
        shifted = {ra, rc[XLEN-1]};
        diff    = shifted - {1'b0, rb};
        if (mul_q) begin
            nra = rc[0] ? sum : ra;
            nrb = rb << 1;
            nrc = rc >> 1;
        end else begin
            nra = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            nrb = rb;
            nrc = {rc[XLEN-2:0], ~diff[XLEN]};
        end
        quo = qneg_q ? -nrc : nrc;
        rmd = rneg_q ? -nra : nra;
        if (mul_q)
            fres = fin(nra, w_q);
        else if (rem_q)
            fres = fin(rmd, w_q);
        else
            fres = fin(quo, w_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush)
                    state_nxt = IDLE;
                else if (valid)
                    state_nxt = special ? DONE : BUSY;
            end
            BUSY: begin
                if (flush)
                    state_nxt = IDLE;
                else if (cnt == CW'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                if (flush)
                    state_nxt = IDLE;
                else if (!hold)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        exe_wait = ((state == IDLE) & valid & ~flush) | (state == BUSY);
        done     = (state == DONE);
        result   = (state == DONE) ? res_q : '0;
    end

    // W-op dividends are pre-shifted so the restoring loop always consumes from the MSB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra     <= '0;
            rb     <= '0;
            rc     <= '0;
            res_q  <= '0;
            cnt    <= '0;
            mul_q  <= 1'b0;
            w_q    <= 1'b0;
            rem_q  <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (accept) begin
            mul_q  <= is_mul;
            w_q    <= is_w;
            rem_q  <= is_rem;
            qneg_q <= is_sgn & (sa ^ sb);
            rneg_q <= sa;
            ra     <= '0;
            cnt    <= is_w ? CW'(32) : CW'(XLEN);
            res_q  <= spec_res;
            if (is_mul) begin
                rb <= opa;
                rc <= opb;
            end else begin
                rb <= mag_b;
                rc <= is_w ? (mag_a << 32) : mag_a;
            end
        end else if (state == BUSY) begin
            ra  <= nra;
            rb  <= nrb;
            rc  <= nrc;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
                res_q <= fres;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, special cases, flush, hold, reset.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [3:0]  op;
    logic [63:0] a, b;
    logic        flush;
    logic        hold;
    logic        exe_wait;
    logic        done;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .hold     (hold),
        .exe_wait (exe_wait),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one op, count exe_wait cycles until done, then check latency and result.
    task automatic run_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                          input int exp_stall, input logic [63:0] exp_res, input string tag);
        int stall;
        stall = 0;
        @(posedge clk); #1;
        valid = 1'b1; op = o; a = x; b = y;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) break;
            if (exe_wait) stall++;
            @(posedge clk); #1;
            valid = 1'b0;
            a = 64'hDEAD_BEEF_0123_4567;
            b = 64'h0F0F_0000_1234_0003;
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_stall"}, 64'(stall), 64'(exp_stall));
        check({tag, "_wait"}, {63'd0, exe_wait}, 64'd0);
        check({tag, "_res"}, result, exp_res);
    endtask

    task automatic finish_idle(input string tag);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_idle_done"}, {63'd0, done}, 64'd0);
        check({tag, "_idle_wait"}, {63'd0, exe_wait}, 64'd0);
        check({tag, "_idle_res"}, result, 64'd0);
    endtask

    initial begin
        bit seen;
        reset = 1'b0; valid = 1'b0; op = 4'd0; a = '0; b = '0; flush = 1'b0; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wait", {63'd0, exe_wait}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_res", result, 64'd0);
        reset = 1'b1;

        run_op(4'd0, 64'd3, -64'd5, 65, 64'hFFFF_FFFF_FFFF_FFF1, "mul");
        finish_idle("mul");
        run_op(4'd2, -64'd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, "div");
        finish_idle("div");
        run_op(4'd4, -64'd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, "rem");
        finish_idle("rem");
        run_op(4'd3, 64'd7, 64'd2, 65, 64'd3, "divu");
        finish_idle("divu");
        run_op(4'd6, 64'h0000_0000_8000_0000, -64'd1, 1, 64'hFFFF_FFFF_8000_0000, "divw_ovf");
        finish_idle("divw_ovf");
        run_op(4'd5, 64'd9, 64'd0, 1, 64'd9, "remu_z");
        finish_idle("remu_z");
        run_op(4'd7, 64'h0000_0000_FFFF_FFFF, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFF, "divuw");
        finish_idle("divuw");
        run_op(4'd1, 64'h1234_5678_7FFF_FFFF, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFE, "mulw");
        run_op(4'd8, 64'h0000_0000_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF, "remw");
        run_op(4'd2, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, "div_z");
        run_op(4'd8, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_0000_0000, 1, 64'hFFFF_FFFF_8000_0000, "remw_z");
        run_op(4'd2, 64'h8000_0000_0000_0000, -64'd1, 1, 64'h8000_0000_0000_0000, "div_ovf");
        run_op(4'd12, 64'd5, 64'd3, 1, 64'd0, "rsv");
        run_op(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 65, 64'h0FFF_FFFF_FFFF_FFFF, "divu_big");
        finish_idle("chain");

        // Abort mid-BUSY, then confirm the aborted op never completes.
        @(posedge clk); #1;
        valid = 1'b1; op = 4'd3; a = 64'd100; b = 64'd7;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_busy_wait", {63'd0, exe_wait}, 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_wait", {63'd0, exe_wait}, 64'd0);
        check("flush_done", {63'd0, done}, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("flush_no_done", {63'd0, seen}, 64'd0);
        run_op(4'd0, 64'd2, 64'd2, 65, 64'd4, "mul_after_flush");
        finish_idle("mul_after_flush");

        // Flush in IDLE suppresses acceptance.
        @(posedge clk); #1;
        valid = 1'b1; flush = 1'b1; op = 4'd0; a = 64'd3; b = 64'd3;
        @(negedge clk);
        check("flush_idle_wait", {63'd0, exe_wait}, 64'd0);
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_next_wait", {63'd0, exe_wait}, 64'd0);
        check("flush_idle_next_done", {63'd0, done}, 64'd0);

        // Asynchronous reset mid-BUSY.
        @(posedge clk); #1;
        valid = 1'b1; op = 4'd0; a = 64'd5; b = 64'd5;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rst_busy_wait", {63'd0, exe_wait}, 64'd0);
        check("rst_busy_done", {63'd0, done}, 64'd0);
        check("rst_busy_res", result, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_op(4'd3, 64'd7, 64'd2, 65, 64'd3, "divu_after_rst");
        finish_idle("divu_after_rst");

        // Hold keeps DONE and its result stable.
        hold = 1'b1;
        run_op(4'd0, 64'd6, 64'd7, 65, 64'd42, "hold");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_done", {63'd0, done}, 64'd1);
            check("hold_res", result, 64'd42);
        end
        hold = 1'b0;
        finish_idle("hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide engine in the execute stage.
- Accepts one operation from the EX pipeline register and produces `exe_wait` to the hazard unit for the whole computation.
- Presents a 64-bit result once finished.
- Honours the EX-stage flush (EWrite == 2'b01, e.g. CSR/exception flush) and holds its result while downstream stages keep (dmem stall).

Parameters:
XLEN, 64, datapath width; W-ops operate on low 32 bits.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
valid  in  1  EX register holds a mul/div instruction
op  in  4  0 MUL, 1 MULW, 2 DIV, 3 DIVU, 4 REM, 5 REMU, 6 DIVW, 7 DIVUW, 8 REMW, 9 REMUW; 10-15 reserved
a  in  XLEN  rs1 operand (post-forwarding)
b  in  XLEN  rs2 operand (post-forwarding)
flush  in  1  EX stage flushed this cycle; abort
hold  in  1  EX stage kept by a downstream stall (EWrite == 2'b11 from dmem_wait)
exe_wait  out  1  to hazard unit; EX must not advance
done  out  1  result valid this cycle
result  out  XLEN  final result

Behaviour:
- States: IDLE, BUSY, DONE. Reset puts the unit in IDLE with exe_wait=0, done=0, result=0, counter=0 and internal registers cleared. Reset mid-operation discards all work.
- exe_wait (combinational) = (IDLE & valid & ~flush) | BUSY. done = DONE. In all other states result is driven as 0.
- IDLE accepting an operation (valid & ~flush):
  - Latch operand magnitudes, sign flags and op.
  - W-ops: a[31:0], b[31:0], sign-extended for signed ops, zero-extended for unsigned ops.
  - Load counter with N = 64, or 32 for W-ops. Go to BUSY.
- Special cases go straight to DONE with no BUSY cycles:
  - Divide by zero: quotient = all ones (in width); remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
  - Reserved op: result = 0.
- Multiply: radix-2 shift-add on the low N bits. Only the low XLEN bits are kept; MULW keeps the low 32 bits.
- Divide: restoring radix-2 on magnitudes, one quotient bit per cycle.
  - Quotient is negated iff signed and operand signs differ.
  - Remainder takes the sign of the dividend.
- W-op results are sign-extended from bit 31, including DIVUW/REMUW.
- BUSY: one iteration per cycle; counter decrements. When the counter reaches 0, go to DONE. Total stall = N+1 cycles with exe_wait=1, then the DONE cycle with exe_wait=0.
- DONE: result stable and done=1.
  - If hold=1, stay in DONE with result unchanged for any number of cycles.
  - If hold=0, the pipeline advances at this edge; go to IDLE.
- flush=1 in any state: next state IDLE, done=0; no partial result ever escapes.
  - flush has priority over hold, valid and counter expiry.
  - In IDLE, flush suppresses acceptance and exe_wait the same cycle.
- hold during BUSY does not pause iteration; the computation continues and then waits in DONE.
- valid deasserted during BUSY is ignored; only flush aborts.
- Operands are latched at acceptance. Later changes on a/b (forwarding updates) do not affect the result.

Test Plan:
- MUL a=3, b=-5 → exe_wait high 65 cycles, then done=1, result=0xFFFFFFFFFFFFFFF1; next cycle IDLE.
- DIV a=-7, b=2 → result=-3 (0xFFFF...FFFD). REM on the same operands → -1. DIVU a=7, b=2 → 3 after 65 stall cycles.
- DIVW a=0x00000000_80000000, b=-1 (overflow) → DONE after 1 cycle, result=0xFFFFFFFF80000000. REMU b=0, a=9 → result=9 after 1 cycle.
- DIVUW a=0xFFFFFFFF, b=1 → 33 stall cycles, result=0xFFFFFFFFFFFFFFFF (sign-extended).
- flush at BUSY cycle 10, then a new MUL 2*2 with valid → no done for the aborted op; second op returns 4; reset asserted mid-BUSY → exe_wait=0, done=0 immediately.
- hold=1 for 5 cycles in DONE → done and result stable for all 5 cycles; hold falls → IDLE next cycle, exe_wait=0.
